sd_host_dat_rx: RTL

SD_HOST_DAT_RX -- requirements
Module: sd_host_dat_rx

---
 rtl/sd_host_dat_rx.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/sd_host_dat_rx.sv
// ---------------------------------------------------------------------------
// sd_host_dat_rx
//
// Host-side receiver for one SD data block on DAT0 in 1-bit bus mode.
// After an arm pulse it waits for the start bit, shifts in BLK_BYTES data
// bytes MSB first, checks the trailing CRC16-CCITT and the end bit, then
// reports completion with a one-cycle done strobe.
//
// Handshake: rx_valid is a one-cycle strobe that qualifies rx_byte. There is
// no ready input. The consumer must take the byte in the cycle rx_valid is
// high, and rx_byte holds its value until the next strobe.
//
// Parameters
//   BLK_BYTES   : data bytes per block (1..2048)
//   TIMEOUT_CYC : cycles with dat_in=1 tolerated while waiting for start bit
//                 (2..65535)
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   arm         : pulse, starts reception of one block (only accepted in IDLE)
//   abort       : pulse, cancels reception in any state (wins over all else)
//   dat_in      : sampled DAT0 line
//   rx_byte     : received data byte
//   rx_valid    : strobe qualifying rx_byte
//   busy        : high whenever the FSM is not in IDLE
//   done        : one-cycle strobe at the end of a block
//   crc_err     : CRC mismatch of the last block, held until the next arm
//   end_err     : end bit was 0 in the last block, held until the next arm
//   timeout     : one-cycle strobe, no start bit arrived in time
//   o_dbg_state : current FSM state encoding for observation
// ---------------------------------------------------------------------------
module sd_host_dat_rx #(
    parameter int BLK_BYTES   = 512,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm,
    input  logic       abort,
    input  logic       dat_in,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       crc_err,
    output logic       end_err,
    output logic       timeout,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        DATA       = 3'd2,
        CRC        = 3'd3,
        END        = 3'd4,
        DONE       = 3'd5
    } state_t;

    localparam logic [11:0] BYTE_LAST = 12'(BLK_BYTES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] CRC_POLY  = 16'h1021;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_timer;
    logic [11:0] r_byte_cnt;
    logic [3:0]  r_bit_cnt;     // low 3 bits index data bits, all 4 index CRC bits
    logic [6:0]  r_shift;
    logic [15:0] r_crc;
    logic        r_crc_bad;
    logic [7:0]  r_rx_byte;
    logic        r_rx_valid;
    logic        r_crc_err;
    logic        r_end_err;
    logic        r_timeout;

    logic        w_arm_ok;
    logic        w_byte_done;
    logic        w_timeout_hit;
    logic [15:0] w_crc_next;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next        = r_state;
        w_arm_ok      = 1'b0;
        w_byte_done   = 1'b0;
        w_timeout_hit = 1'b0;

        case (r_state)
            IDLE: begin
                if (arm) begin
                    w_next   = WAIT_START;
                    w_arm_ok = 1'b1;
                end
            end
            WAIT_START: begin
                if (!dat_in) begin
                    w_next = DATA;
                end else if (r_timer == TMO_LAST) begin
                    w_next        = IDLE;
                    w_timeout_hit = 1'b1;
                end
            end
            DATA: begin
                if (r_bit_cnt[2:0] == 3'd7) begin
                    w_byte_done = 1'b1;
                    if (r_byte_cnt == BYTE_LAST) begin
                        w_next = CRC;
                    end
                end
            end
            CRC: begin
                if (r_bit_cnt == 4'd15) begin
                    w_next = END;
                end
            end
            END:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase

        // abort overrides arm, timeout and every completion event
        if (abort) begin
            w_next        = IDLE;
            w_arm_ok      = 1'b0;
            w_byte_done   = 1'b0;
            w_timeout_hit = 1'b0;
        end
    end

    // Serial CRC16-CCITT step for the bit currently on dat_in
    assign w_crc_next = {r_crc[14:0], 1'b0} ^ ({16{r_crc[15] ^ dat_in}} & CRC_POLY);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer    <= '0;
            r_byte_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_crc      <= '0;
            r_crc_bad  <= 1'b0;
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_crc_err  <= 1'b0;
            r_end_err  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_timeout  <= w_timeout_hit;

            if (w_arm_ok) begin
                r_timer    <= '0;
                r_byte_cnt <= '0;
                r_bit_cnt  <= '0;
                r_crc      <= '0;
                r_crc_bad  <= 1'b0;
                r_crc_err  <= 1'b0;
                r_end_err  <= 1'b0;
            end

            if (!abort) begin
                case (r_state)
                    WAIT_START: begin
                        if (!dat_in) begin
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + 16'd1;
                        end
                    end
                    DATA: begin
                        r_shift   <= {r_shift[5:0], dat_in};
                        r_crc     <= w_crc_next;
                        r_bit_cnt <= {1'b0, r_bit_cnt[2:0] + 3'd1};
                        if (w_byte_done) begin
                            r_rx_byte  <= {r_shift, dat_in};
                            r_rx_valid <= 1'b1;
                            r_byte_cnt <= r_byte_cnt + 12'd1;
                        end
                    end
                    CRC: begin
                        // Shift the computed CRC out MSB first against the line
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_crc     <= {r_crc[14:0], 1'b0};
                        if (dat_in != r_crc[15]) begin
                            r_crc_bad <= 1'b1;
                        end
                    end
                    END: begin
                        r_end_err <= ~dat_in;
                        r_crc_err <= r_crc_bad;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rx_byte     = r_rx_byte;
    assign rx_valid    = r_rx_valid;
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign crc_err     = r_crc_err;
    assign end_err     = r_end_err;
    assign timeout     = r_timeout;
    assign o_dbg_state = r_state;

endmodule
